// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension funct3 codes and the mul/div FSM state type.
package riscv_pkg;

   localparam logic [6:0] OP_M_FUNCT7 = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the multi-cycle controller and the mul/div unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, funct3, a, b, input busy, done, result);
   modport slave  (input start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with sign fix-up in a final cycle.
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave io
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t     state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;
   logic              dneg_q, dneg_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN:0]     rem_q, rem_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              is_div, sgn_a, sgn_b, a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b, quo, rmd;
   logic [XLEN:0]     msum, shl, trial;
   logic [2*XLEN-1:0] prod;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      dneg_d   = dneg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      result_d = result_q;

      is_div = io.funct3[2];
      sgn_a  = (io.funct3 == F3_MULH) || (io.funct3 == F3_MULHSU) ||
               (io.funct3 == F3_DIV)  || (io.funct3 == F3_REM);
      sgn_b  = (io.funct3 == F3_MULH) || (io.funct3 == F3_DIV) || (io.funct3 == F3_REM);
      a_neg  = sgn_a & io.a[XLEN-1];
      b_neg  = sgn_b & io.b[XLEN-1];
      mag_a  = a_neg ? -io.a : io.a;
      mag_b  = b_neg ? -io.b : io.b;

      // Multiply keeps the multiplier in acc low half; divide keeps the dividend there
      // and shifts quotient bits in behind it.
      msum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
      shl   = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
      trial = shl - {1'b0, opnd_q};
      prod  = neg_q ? -acc_q : acc_q;
      quo   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rmd   = dneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (io.start) begin
               f3_d    = io.funct3;
               cnt_d   = CW'(XLEN-1);
               opnd_d  = is_div ? mag_b : mag_a;
               acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
               rem_d   = '0;
               neg_d   = a_neg ^ b_neg;
               dneg_d  = a_neg;
               state_d = CALC;
               if (is_div && io.b == '0) begin
                  result_d = io.funct3[1] ? io.a : '1;
                  state_d  = DONE;
               end else if (is_div && !io.funct3[0] && io.a == MOST_NEG && io.b == '1) begin
                  result_d = io.funct3[1] ? '0 : io.a;
                  state_d  = DONE;
               end
            end
         end
         CALC: begin
            if (cnt_q == '0) state_d = FIX;
            else             cnt_d   = cnt_q - 1'b1;
            if (f3_q[2]) begin
               rem_d             = trial[XLEN] ? shl : trial;
               acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], ~trial[XLEN]};
            end else if (acc_q[0]) begin
               acc_d = {msum, acc_q[XLEN-1:1]};
            end else begin
               acc_d = {1'b0, acc_q[2*XLEN-1:1]};
            end
         end
         FIX: begin
            if (f3_q[2])             result_d = f3_q[1] ? rmd : quo;
            else if (f3_q == F3_MUL) result_d = prod[XLEN-1:0];
            else                     result_d = prod[2*XLEN-1:XLEN];
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         dneg_q   <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         dneg_q   <= dneg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

   assign io.busy   = (state_q == CALC) || (state_q == FIX);
   assign io.done   = (state_q == DONE);
   assign io.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 and XLEN=8: vector table plus
// hand-written abort, ignored-start and back-to-back sequences.
module tb_muldiv_unit;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_unit_if #(.XLEN(32)) i32 ();
   muldiv_unit_if #(.XLEN(8))  i8  ();

   muldiv_unit #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .io(i32.slave));
   muldiv_unit #(.XLEN(8))  u8  (.clk(clk), .rst(rst), .io(i8.slave));

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      bit          w8;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit w8, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
      if (w8) begin
         i8.start = st; i8.funct3 = f3; i8.a = a[7:0]; i8.b = b[7:0];
      end else begin
         i32.start = st; i32.funct3 = f3; i32.a = a; i32.b = b;
      end
   endtask

   task automatic get(input bit w8, output logic bz, output logic dn, output logic [31:0] r);
      if (w8) begin
         bz = i8.busy; dn = i8.done; r = {24'h0, i8.result};
      end else begin
         bz = i32.busy; dn = i32.done; r = i32.result;
      end
   endtask

   function automatic vec_t mk(bit w8, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                               logic [31:0] exp, int lat);
      vec_t v;
      v.w8 = w8; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      return v;
   endfunction

   // Start in cycle 0, follow busy each cycle, expect done exactly in cycle lat.
   task automatic run_op(input int idx, input vec_t v);
      int dc, bad_busy;
      logic bz, dn;
      logic [31:0] r, res;
      string nm;
      nm = $sformatf("vec%0d", idx);
      dc = -1; bad_busy = 0; res = 'x;
      drive(v.w8, 1'b1, v.f3, v.a, v.b);
      get(v.w8, bz, dn, r);
      if (bz !== 1'b0) bad_busy++;
      for (int c = 1; c <= v.lat + 4 && dc < 0; c++) begin
         step();
         if (c == 1) drive(v.w8, 1'b0, 3'b000, '0, '0);
         get(v.w8, bz, dn, r);
         if (bz !== (c < v.lat)) bad_busy++;
         if (dn === 1'b1) begin dc = c; res = r; end
      end
      chk({nm, " done_cycle"}, 32'(dc), 32'(v.lat));
      chk({nm, " busy_profile_errs"}, 32'(bad_busy), 32'd0);
      chk({nm, " result"}, res, v.exp);
      step();
      get(v.w8, bz, dn, r);
      chk({nm, " done_one_cycle"}, {31'd0, dn}, 32'd0);
   endtask

   initial begin
      logic bz, dn;
      logic [31:0] r, r1, r2;
      int d1, d2;

      rst = 1'b1;
      drive(1'b0, 1'b0, 3'b000, '0, '0);
      drive(1'b1, 1'b0, 3'b000, '0, '0);
      step(); step();
      get(1'b0, bz, dn, r);
      chk("reset busy", {31'd0, bz}, 32'd0);
      chk("reset done", {31'd0, dn}, 32'd0);
      chk("reset result", r, 32'd0);
      get(1'b1, bz, dn, r);
      chk("reset8 result", r, 32'd0);
      rst = 1'b0;
      step();

      tv.push_back(mk(0, F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34));
      tv.push_back(mk(0, F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34));
      tv.push_back(mk(0, F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34));
      tv.push_back(mk(0, F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34));
      tv.push_back(mk(0, F3_MUL,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34));
      tv.push_back(mk(0, F3_MULHU,  32'h80000000, 32'd2,        32'd1,        34));
      tv.push_back(mk(0, F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34));
      tv.push_back(mk(0, F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34));
      tv.push_back(mk(0, F3_DIVU,   32'd100,      32'd7,        32'd14,       34));
      tv.push_back(mk(0, F3_REMU,   32'd100,      32'd7,        32'd2,        34));
      tv.push_back(mk(0, F3_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34));
      tv.push_back(mk(0, F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34));
      tv.push_back(mk(0, F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34));
      tv.push_back(mk(0, F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34));
      tv.push_back(mk(0, F3_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34));
      tv.push_back(mk(0, F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1));
      tv.push_back(mk(0, F3_REM,    32'd5,        32'd0,        32'd5,        1));
      tv.push_back(mk(0, F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1));
      tv.push_back(mk(0, F3_REMU,   32'd5,        32'd0,        32'd5,        1));
      tv.push_back(mk(0, F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
      tv.push_back(mk(0, F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1));
      tv.push_back(mk(1, F3_MUL,    32'h0F,       32'h0F,       32'hE1,       10));
      tv.push_back(mk(1, F3_MULH,   32'h80,       32'h80,       32'h40,       10));
      tv.push_back(mk(1, F3_DIV,    32'hF9,       32'h02,       32'hFD,       10));
      tv.push_back(mk(1, F3_DIV,    32'h80,       32'hFF,       32'h80,       1));
      tv.push_back(mk(1, F3_REMU,   32'hC8,       32'h07,       32'h04,       10));

      foreach (tv[i]) run_op(i, tv[i]);

      // A start while busy must not disturb the running DIVU.
      d1 = -1; r1 = '0;
      drive(0, 1'b1, F3_DIVU, 32'd100, 32'd7);
      for (int c = 1; c <= 40 && d1 < 0; c++) begin
         step();
         if (c == 1 || c == 11) drive(0, 1'b0, 3'b000, '0, '0);
         if (c == 10) drive(0, 1'b1, F3_MUL, 32'd3, 32'd3);
         get(0, bz, dn, r);
         if (dn === 1'b1) begin d1 = c; r1 = r; end
      end
      chk("ignored_start done_cycle", 32'(d1), 32'd34);
      chk("ignored_start result", r1, 32'd14);
      step();

      // Reset mid-op (with a colliding start), then a fresh MUL.
      d1 = -1; r1 = '0;
      drive(0, 1'b1, F3_DIV, 32'd100, 32'd7);
      for (int c = 1; c <= 52 && d1 < 0; c++) begin
         step();
         if (c == 1 || c == 15) drive(0, 1'b0, 3'b000, '0, '0);
         if (c == 12) begin rst = 1'b1; drive(0, 1'b1, F3_MUL, 32'd5, 32'd5); end
         if (c == 13) begin rst = 1'b0; drive(0, 1'b0, 3'b000, '0, '0); end
         if (c == 14) drive(0, 1'b1, F3_MUL, 32'd3, 32'd4);
         get(0, bz, dn, r);
         if (c == 13) begin
            chk("abort busy", {31'd0, bz}, 32'd0);
            chk("abort done", {31'd0, dn}, 32'd0);
            chk("abort result", r, 32'd0);
         end
         if (c > 13 && dn === 1'b1) begin d1 = c; r1 = r; end
      end
      chk("post_reset done_cycle", 32'(d1), 32'd48);
      chk("post_reset result", r1, 32'd12);
      step();

      // Back-to-back: second start issued in the first op's DONE cycle.
      d1 = -1; d2 = -1; r1 = '0; r2 = '0;
      drive(0, 1'b1, F3_MUL, 32'd7, 32'd3);
      for (int c = 1; c <= 80 && d2 < 0; c++) begin
         step();
         if (c == 1 || c == d1 + 1) drive(0, 1'b0, 3'b000, '0, '0);
         get(0, bz, dn, r);
         if (c == 35) begin
            chk("b2b busy_after_reissue", {31'd0, bz}, 32'd1);
            chk("b2b result_held", r, 32'd21);
         end
         if (dn === 1'b1) begin
            if (d1 < 0) begin
               d1 = c; r1 = r;
               drive(0, 1'b1, F3_DIVU, 32'd9, 32'd2);
            end else begin
               d2 = c; r2 = r;
            end
         end
      end
      chk("b2b first done_cycle", 32'(d1), 32'd34);
      chk("b2b first result", r1, 32'd21);
      chk("b2b second done_cycle", 32'(d2), 32'd68);
      chk("b2b second result", r2, 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the multi-cycle core, parametrised in operand width. It sits beside the ALU in the multi-cycle datapath. The controller issues a one-cycle `start` with the decoded `funct3` and the A/B register operands. It then holds in a wait state until `done`, and writes `result` back through the result mux. Radix-2 shift-add multiply and restoring divide take one bit per cycle.

## Interface
- `XLEN`, default 32: operand/result width; any value ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request pulse; sampled only when not busy.
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand (multiplicand / dividend).
- `b`  in  XLEN  rs2 operand (multiplier / divisor).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `result` valid in that cycle.
- `result`  out  XLEN  registered result; held until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, internal counter 0.
- IDLE/DONE with `start`=1:
  - Latch `funct3`.
  - Latch operand magnitudes. Signed operands are `a` for MULH/MULHSU/DIV/REM, and `b` for MULH/DIV/REM; all others are unsigned.
  - Latch the result-sign flag.
  - Load counter with XLEN-1.
  - Go to CALC. Exception: a special case goes straight to DONE.
- Special cases, divide ops only, decided at start:
  - `b`==0: DIV/DIVU give all ones; REM/REMU give `a`.
  - Signed overflow, DIV/REM with `a`=100…0 and `b`=all ones: DIV gives `a`, REM gives 0.
- CALC, one iteration per cycle; counter decrements and moves to FIX at 0.
  - Multiply: 2·XLEN product accumulator with shift-add on the multiplier LSB.
  - Divide: XLEN+1-bit partial remainder with restoring subtract and a quotient shift-in.
- FIX:
  - Multiply: negate the 2·XLEN product if the sign flag is set. Select the low half for MUL, the high half otherwise.
  - Quotient: negate if the operand signs differ, signed ops only.
  - Remainder: takes the sign of the dividend.
  - Load `result`, go to DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE. A `start` in DONE is accepted exactly as in IDLE (back-to-back issue).
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- Operand inputs may change freely after the start cycle.
- Width rule: all arithmetic is modulo 2^XLEN, or 2^(2·XLEN) for the product. Negating the most-negative value wraps to itself.

## Timing
- `start` high in cycle 0 (normal path):
  - CALC occupies cycles 1…XLEN.
  - FIX is cycle XLEN+1.
  - `done`=1 in cycle XLEN+2, which is cycle 34 for XLEN=32.
- Special-case path: `done`=1 in cycle 1.
- `busy`=1 in CALC and FIX only. It is 0 in IDLE and DONE, and 0 in cycle 0 itself.
- `result` changes only on the edge entering DONE.
- Throughput: one op per XLEN+2 cycles with back-to-back issue.
- `rst` high during any cycle: state returns to IDLE on that edge. `busy`, `done` and `result` are 0 the next cycle, and the in-flight op is discarded. `rst` overrides a simultaneous `start`.

## Structure
- Shared package `riscv_pkg`:
  - `funct3` encodings for the M extension as named localparams.
  - The `muldiv_state_t` enum (IDLE, CALC, FIX, DONE).
  - `OP_M_FUNCT7` = 7'b0000001 for controller decode.
- No sub-module: single module, with counter, accumulators and FSM in one `always` block plus combinational next-step logic.
- Controller integration: a new multi-cycle state asserts `start` once, waits for `done`, then writes back.

## Test plan
- MUL, `a`=7, `b`=0xFFFFFFFD (-3), start in cycle 0 → `busy` high in cycles 1–33; `done` in cycle 34; `result`=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides of -7 by 2, and 100 by 7:
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - Each gives `done` in cycle 34.
- Special cases, each with `done` in cycle 1 and `busy` never high:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Robustness sequence:
  - `start` re-pulsed with new operands in cycle 10 → ignored; original result returned.
  - `rst` in cycle 12 → `busy`/`done`/`result` = 0 in cycle 13.
  - Fresh MUL 3×4 started in cycle 14 → `result`=12 in cycle 48.
- Back-to-back: second `start` (DIVU 9/2) asserted in the first op's DONE cycle → accepted; `result`=4 with `done` XLEN+2 cycles later. Repeat with XLEN=8: MUL 0x0F×0x0F → 0xE1, `done` in cycle 10.
